// File: rtl/la_pkg.sv
// la_pkg: shared types for the logic-analyser capture engine.
// Capture FSM states, trigger mode codes and a state helper.
package la_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DONE
  } la_state_t;

  localparam logic [2:0] LA_MODE_LOW  = 3'd0;
  localparam logic [2:0] LA_MODE_HIGH = 3'd1;
  localparam logic [2:0] LA_MODE_RISE = 3'd2;
  localparam logic [2:0] LA_MODE_FALL = 3'd3;
  localparam logic [2:0] LA_MODE_ANY  = 3'd4;
  localparam logic [2:0] LA_MODE_IMM  = 3'd5;
  localparam logic [2:0] LA_MODE_PAT  = 3'd6;
  localparam logic [2:0] LA_MODE_IMM2 = 3'd7;

  function automatic logic la_writing(
    input la_state_t s
  );
    return s inside {PRE, ARMED, POST};
  endfunction

endpackage

// File: rtl/la_capture_trig_eval.sv
// la_trig_eval: combinational trigger condition on one sample pair.
// In: s1 (current), s2 (previous), mode, channel, mask, pattern. Out: hit.
// Pattern mode is a real comparator only with LA_PATTERN_TRIG_EN.
module la_trig_eval
  import la_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int SEL_W = 3
) (
  input  logic [CH_W-1:0]  s1,
  input  logic [CH_W-1:0]  s2,
  input  logic [2:0]       mode,
  input  logic [SEL_W-1:0] channel,
  input  logic [CH_W-1:0]  mask,
  input  logic [CH_W-1:0]  pattern,
  output logic             hit
);

  logic in_rng;
  logic cur;
  logic prv;
  logic pat_hit;

  always_comb begin
    in_rng = 1'b0;
    cur    = 1'b0;
    prv    = 1'b0;
    for (int i = 0; i < CH_W; i++) begin
      if (channel == SEL_W'(i)) begin
        in_rng = 1'b1;
        cur    = s1[i];
        prv    = s2[i];
      end
    end
  end

`ifdef LA_PATTERN_TRIG_EN
  assign pat_hit = (s1 & mask) == (pattern & mask);
`else
  logic unused_pat;
  assign unused_pat = ^{mask, pattern};
  assign pat_hit    = 1'b1;
`endif

  always_comb begin
    hit = 1'b0;
    unique case (mode)
      LA_MODE_LOW:  hit = in_rng & ~cur;
      LA_MODE_HIGH: hit = in_rng & cur;
      LA_MODE_RISE: hit = in_rng & cur & ~prv;
      LA_MODE_FALL: hit = in_rng & ~cur & prv;
      LA_MODE_ANY:  hit = in_rng & (cur ^ prv);
      LA_MODE_IMM:  hit = 1'b1;
      LA_MODE_PAT:  hit = pat_hit;
      LA_MODE_IMM2: hit = 1'b1;
    endcase
  end

endmodule

// File: rtl/la_capture.sv
// la_capture: strobe-driven capture into a circular 2**ADDR_W RAM.
// Ports: clk_50M/rst_n, strobe, start/abort, trigger config, data_in;
// RAM write port, trig_addr/start_addr, busy/triggered/done.
// Optional: LA_PATTERN_TRIG_EN enables the pattern trigger (mode 6).
module la_capture
  import la_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int ADDR_W = 17,
  parameter int SEL_W  = $clog2(CH_W)
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              clk_sample,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode_sel,
  input  logic [SEL_W-1:0]  channel_sel,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [CH_W-1:0]   trig_mask,
  input  logic [CH_W-1:0]   trig_pattern,
  input  logic [CH_W-1:0]   data_in,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH_W-1:0]   wr_data,
  output logic              wren,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  la_state_t state;
  la_state_t state_nx;

  logic [CH_W-1:0]   s1;
  logic [CH_W-1:0]   s2;
  logic [CH_W-1:0]   s1_nx;
  logic [CH_W-1:0]   s2_nx;
  logic [2:0]        mode_q;
  logic [SEL_W-1:0]  chan_q;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [CH_W-1:0]   mask_v;
  logic [CH_W-1:0]   pat_v;
  logic              hit;
  logic              go;
  logic              wr;

`ifdef LA_PATTERN_TRIG_EN
  logic [CH_W-1:0] mask_q;
  logic [CH_W-1:0] pat_q;
  assign mask_v = mask_q;
  assign pat_v  = pat_q;
`else
  assign mask_v = trig_mask;
  assign pat_v  = trig_pattern;
`endif

  // The trigger judges the sample being written this strobe,
  // so evaluate the post-shift synchroniser values.
  assign s1_nx = clk_sample ? data_in : s1;
  assign s2_nx = clk_sample ? s1 : s2;

  // pre_len is ADDR_W wide, so it is already bounded by DEPTH-1.
  assign go = start & ~abort
            & ((state == IDLE) | (state == DONE));
  assign wr = clk_sample & ~abort & la_writing(state);

  la_trig_eval #(
    .CH_W  (CH_W),
    .SEL_W (SEL_W)
  ) u_eval (
    .s1      (s1_nx),
    .s2      (s2_nx),
    .mode    (mode_q),
    .channel (chan_q),
    .mask    (mask_v),
    .pattern (pat_v),
    .hit     (hit)
  );

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE:
          if (start)
            state_nx = (pre_len == '0) ? ARMED : PRE;
        PRE:
          if (clk_sample && cnt == pre_q - ADDR_W'(1))
            state_nx = ARMED;
        ARMED:
          if (clk_sample && hit)
            state_nx = (pre_q == '1) ? DONE : POST;
        POST:
          if (clk_sample && cnt == ADDR_W'(1))
            state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s1         <= '0;
      s2         <= '0;
      mode_q     <= '0;
      chan_q     <= '0;
      pre_q      <= '0;
      ptr        <= '0;
      cnt        <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wren       <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
`ifdef LA_PATTERN_TRIG_EN
      mask_q     <= '0;
      pat_q      <= '0;
`endif
    end else begin
      state <= state_nx;
      s1    <= s1_nx;
      s2    <= s2_nx;
      wren  <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (go) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        triggered <= 1'b0;
        ptr       <= '0;
        cnt       <= '0;
        mode_q    <= mode_sel;
        chan_q    <= channel_sel;
        pre_q     <= pre_len;
`ifdef LA_PATTERN_TRIG_EN
        mask_q    <= trig_mask;
        pat_q     <= trig_pattern;
`endif
      end else if (state == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (wr) begin
        wren    <= 1'b1;
        wr_addr <= ptr;
        wr_data <= data_in;
        ptr     <= ptr + ADDR_W'(1);
        unique case (state)
          PRE: cnt <= cnt + ADDR_W'(1);
          ARMED:
            if (hit) begin
              trig_addr  <= ptr;
              start_addr <= ptr - pre_q;
              triggered  <= 1'b1;
              // Remaining post samples: DEPTH-1-pre_len.
              cnt        <= ~pre_q;
            end
          POST: cnt <= cnt - ADDR_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule
